// File: rtl/alu_seq_ctrl.sv
// Four-state sequencer around an external combinational ALU: fetch operands,
// capture the ALU result, write it back. Owns the register file and host port.
module alu_seq_ctrl #(
   parameter int NREG = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [15:0] instr,
   input  logic        host_we,
   input  logic [2:0]  host_addr,
   input  logic [15:0] host_wdata,
   input  logic [2:0]  host_raddr,
   output logic [15:0] host_rdata,
   output logic [15:0] alu_valA,
   output logic [15:0] alu_valB,
   output logic [3:0]  alu_aluop,
   output logic        alu_sub,
   output logic        alu_lr,
   output logic [3:0]  alu_shift,
   input  logic [15:0] alu_result,
   input  logic [3:0]  alu_cc,
   output logic        done,
   output logic        err,
   output logic [15:0] result_out,
   output logic [3:0]  flags
);

   typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

   state_t      state, state_nxt;
   logic [15:0] regs [NREG];
   logic [15:0] ir;
   logic [15:0] hold_res;
   logic [3:0]  hold_cc;
   logic [3:0]  op;
   logic [2:0]  rd, ra, rb;
   logic        illegal;

   assign op      = ir[15:12];
   assign rd      = ir[11:9];
   assign ra      = ir[8:6];
   assign rb      = ir[5:3];
   assign illegal = (op > 4'd10);

   assign host_rdata = regs[host_raddr];

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      instr_ready = 1'b0;
      case (state)
         IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) state_nxt = READ;
         end
         READ:    state_nxt = EXEC;
         EXEC:    state_nxt = WB;
         WB:      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= 16'h0;
         ir         <= 16'h0;
         hold_res   <= 16'h0;
         hold_cc    <= 4'h0;
         alu_valA   <= 16'h0;
         alu_valB   <= 16'h0;
         alu_aluop  <= 4'h0;
         alu_sub    <= 1'b0;
         alu_lr     <= 1'b0;
         alu_shift  <= 4'h0;
         done       <= 1'b0;
         err        <= 1'b0;
         result_out <= 16'h0;
         flags      <= 4'h0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               // Host write lands this edge, so an instruction accepted now reads it in READ.
               if (host_we)     regs[host_addr] <= host_wdata;
               if (instr_valid) ir <= instr;
            end
            READ: begin
               alu_valA  <= regs[ra];
               alu_valB  <= regs[rb];
               alu_shift <= regs[rb][3:0];
               alu_aluop <= op;
               alu_sub   <= (op == 4'd1);
               alu_lr    <= (op == 4'd2) || (op == 4'd5);
            end
            EXEC: begin
               hold_res <= alu_result;
               hold_cc  <= alu_cc;
            end
            WB: begin
               done <= 1'b1;
               err  <= illegal;
               if (!illegal) begin
                  regs[rd]   <= hold_res;
                  result_out <= hold_res;
                  flags      <= hold_cc;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter: NREG, default 8, number of 16-bit general registers (addressed by 3-bit fields).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 instr_valid  input  1  instruction offered.
REQ-005 instr_ready  output  1  controller can accept an instruction.
REQ-006 instr  input  16  op[15:12], rd[11:9], ra[8:6], rb[5:3], [2:0] ignored.
REQ-007 host_we / host_addr / host_wdata  input  1/3/16  host register write.
REQ-008 host_raddr / host_rdata  input 3 / output 16  combinational host register read.
REQ-009 alu_valA, alu_valB  output  16  registered ALU operands.
REQ-010 alu_aluop  output  4; alu_sub output 1; alu_lr output 1; alu_shift output 4: registered ALU controls.
REQ-011 alu_result  input  16; alu_cc input 4 {N,Z,C,V}: combinational ALU outputs.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 err  output  1  qualifies done: illegal opcode.
REQ-014 result_out  output  16; flags output 4: last committed result and cc.

Function
REQ-015 FSM states: IDLE, READ, EXEC, WB; instr_ready SHALL be 1 only in IDLE.
REQ-016 IDLE: instr_valid=1 -> latch instr, go READ; otherwise stay.
REQ-017 READ: alu_valA<=reg[ra], alu_valB<=reg[rb], alu_shift<=reg[rb][3:0], alu_aluop<=op; go EXEC.
REQ-018 alu_sub=1 only for op 0001; alu_lr=1 for op 0010 (SHL) and 0101 (ROL), else 0.
REQ-019 Legal ops 0000-1010 (ADD,SUB,SHL,ASR,LSR,ROL,ROR,AND,OR,NOT,XOR); 1011-1111 illegal.
REQ-020 EXEC: capture alu_result and alu_cc into internal holding registers; go WB.
REQ-021 WB, legal op: reg[rd]<=held result, result_out<=held result, flags<=held cc, done=1, err=0; go IDLE.
REQ-022 WB, illegal op: no register, result_out or flags update; done=1, err=1; go IDLE.
REQ-023 Latency: handshake at edge T -> done high in cycle T+3; next accept earliest at T+4 edge (one per 4 cycles).
REQ-024 Host writes SHALL take effect only in IDLE; host_we in READ/EXEC/WB ignored (dropped, not queued).
REQ-025 Host write and instruction accept in same IDLE cycle: both occur; READ sees new register value.
REQ-026 rd==ra or rd==rb allowed; operands read in READ, so writeback never affects the current operation.
REQ-027 err SHALL be 0 whenever done is 0.
REQ-028 host_rdata reflects register contents after the most recent edge (no bypass).

Reset
REQ-029 rst SHALL force IDLE and clear all registers, alu_* outputs, result_out, flags, done, err to 0 on the next edge.
REQ-030 rst mid-operation (READ/EXEC/WB) abandons the instruction: no writeback, no done pulse.
REQ-031 rst takes priority over instr_valid and host_we in the same cycle.

Verification
REQ-032 Host r1=0x7FFF, r2=0x0001; ADD rd=3 -> done at T+3, r3=0x8000, flags=4'b1001, err=0.
REQ-033 r4=0x0001, r5=0x0004; SHL rd=6 ra=4 rb=5 -> alu_lr=1, alu_shift=4, r6=0x0010, flags=4'b0000.
REQ-034 r4=0x0001, r7=0x0001; ROR rd=4 ra=4 rb=7 -> alu_lr=0, r4=0x8000, flags N=1.
REQ-035 op=1011 -> done=1, err=1 at T+3; all registers and flags unchanged; instr_ready back to 1 at T+4.
REQ-036 rst asserted in EXEC -> IDLE next cycle, no done, rd unchanged; host_we during READ -> register unchanged.
REQ-037 Back-to-back instr_valid held high: accepts exactly every 4 cycles, one done per instruction.
